mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: sequences multi-cycle mult/div ops, owns HI/LO,
// and raises the pipeline stall for HI/LO-class instructions while an op is pending.
module mdu_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        md_use,
    input  logic        rd_sel,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_rd
);

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [0:0]        state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [DATA_W-1:0] op_a, op_a_d;
    logic [DATA_W-1:0] op_b, op_b_d;
    logic [1:0]        op_q, op_q_d;
    logic              busy_d;
    logic [DATA_W-1:0] hi_d, lo_d;

    logic                accept;
    logic                is_signed;
    logic [2*DATA_W-1:0] ext_a, ext_b, prod;
    logic                neg_a, neg_b, div_zero;
    logic [DATA_W-1:0]   mag_a, mag_b, den, mag_q, mag_r, quo, rem;

    assign accept = start & ~flush & (state == IDLE) & (md_op <= OP_MTLO);

    // Datapath on latched operands; bit 0 of the op selects unsigned variants.
    assign is_signed = ~op_q[0];
    assign ext_a     = is_signed ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {DATA_W'(0), op_a};
    assign ext_b     = is_signed ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {DATA_W'(0), op_b};
    assign prod      = ext_a * ext_b;

    // Signed divide via magnitudes keeps MIN/-1 well-defined (quotient wraps to MIN).
    assign neg_a    = is_signed & op_a[DATA_W-1];
    assign neg_b    = is_signed & op_b[DATA_W-1];
    assign mag_a    = neg_a ? (~op_a + DATA_W'(1)) : op_a;
    assign mag_b    = neg_b ? (~op_b + DATA_W'(1)) : op_b;
    assign div_zero = (op_b == DATA_W'(0));
    assign den      = div_zero ? DATA_W'(1) : mag_b;
    assign mag_q    = mag_a / den;
    assign mag_r    = mag_a % den;
    assign quo      = (neg_a ^ neg_b) ? (~mag_q + DATA_W'(1)) : mag_q;
    assign rem      = neg_a ? (~mag_r + DATA_W'(1)) : mag_r;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_a_d  = op_a;
        op_b_d  = op_b;
        op_q_d  = op_q;
        busy_d  = busy;
        hi_d    = hi;
        lo_d    = lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (md_op == OP_MTHI) begin
                        hi_d = rs_val;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = rs_val;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                        op_a_d  = rs_val;
                        op_b_d  = rt_val;
                        op_q_d  = md_op[1:0];
                        cnt_d   = md_op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                    end
                end
            end
            RUN: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = CNT_W'(0);
                    if (!op_q[1]) begin
                        hi_d = prod[2*DATA_W-1:DATA_W];
                        lo_d = prod[DATA_W-1:0];
                    end else if (!div_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = CNT_W'(0);
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= CNT_W'(0);
            op_a  <= DATA_W'(0);
            op_b  <= DATA_W'(0);
            op_q  <= 2'd0;
            busy  <= 1'b0;
            hi    <= DATA_W'(0);
            lo    <= DATA_W'(0);
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            op_a  <= op_a_d;
            op_b  <= op_b_d;
            op_q  <= op_q_d;
            busy  <= busy_d;
            hi    <= hi_d;
            lo    <= lo_d;
        end
    end

    // Only mult/div acceptance stalls; mthi/mtlo complete at the accepting edge.
    assign stall = md_use & (busy | (start & (state == IDLE) & (md_op <= 3'd3) & ~flush));
    assign md_rd = rd_sel ? hi : lo;

endmodule
